// File: rtl/rr_arb_pkg.sv
// Shared types, default sizes and helpers for the round-robin register arbiter.
package rr_arb_pkg;

    // Arbiter occupancy: nobody granted, or exactly one requester granted.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request after 'last', wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int OW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic            any,
    output logic [OW-1:0]   winner
);

    // Scan from farthest to nearest so the nearest hit after 'last' wins.
    always_comb begin
        any    = 1'b0;
        winner = last;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) begin
                any    = 1'b1;
                winner = OW'((int'(last) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter serialising writes from NREQ requesters into one
// shared WIDTH-bit register, with bounded back-to-back locking.
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             lock,
    input  logic [NREQ*WIDTH-1:0]       wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [clog2_min1(NREQ)-1:0] owner,
    output logic [WIDTH-1:0]            q,
    output logic                        wr_valid,
    output logic                        busy
);

    localparam int OW = clog2_min1(NREQ);
    localparam int HW = clog2_min1(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD - 1);

    arb_state_t        state_reg, state_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [OW-1:0]     owner_reg, owner_next;
    logic [OW-1:0]     last_reg, last_next;
    logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [WIDTH-1:0]  q_reg, q_next;
    logic              wr_valid_reg, wr_valid_next;

    logic              pick_any;
    logic [OW-1:0]     pick_winner;
    logic [NREQ-1:0]   winner_onehot;
    logic [WIDTH-1:0]  wdata_slice [NREQ];
    logic              commit;
    logic              hold;

    rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .req    (req),
        .last   (last_reg),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Unpack write data and decode the winner into a one-hot grant.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign wdata_slice[gi]   = wdata[gi*WIDTH +: WIDTH];
        assign winner_onehot[gi] = (pick_winner == OW'(gi));
    end

    // A write commits only while the owner still requests; only the owner's
    // slice is ever selected, so other slices cannot leak into q.
    assign commit = (state_reg == ARB_GRANT) && req[owner_reg];
    assign hold   = commit && lock[owner_reg] && (hold_cnt_reg < HOLD_LIMIT);

    // Next grant: keep a locked owner under its ceiling, otherwise re-arbitrate.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        if (hold) begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
        end else begin
            hold_cnt_next = '0;
            if (pick_any) begin
                state_next = ARB_GRANT;
                gnt_next   = winner_onehot;
                owner_next = pick_winner;
                last_next  = pick_winner;
            end else begin
                state_next = ARB_IDLE;
                gnt_next   = '0;
            end
        end
    end

    // Next register value and write strobe.
    always_comb begin
        q_next        = q_reg;
        wr_valid_next = 1'b0;
        if (commit) begin
            q_next        = wdata_slice[owner_reg];
            wr_valid_next = 1'b1;
        end
    end

    // State registers; last starts at NREQ-1 so requester 0 is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ARB_IDLE;
            gnt_reg      <= '0;
            owner_reg    <= '0;
            last_reg     <= OW'(NREQ - 1);
            hold_cnt_reg <= '0;
            q_reg        <= '0;
            wr_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            q_reg        <= q_next;
            wr_valid_reg <= wr_valid_next;
        end
    end

    assign gnt      = gnt_reg;
    assign owner    = owner_reg;
    assign q        = q_reg;
    assign wr_valid = wr_valid_reg;
    assign busy     = (state_reg == ARB_GRANT);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter: directed scenarios plus random
// traffic, compared each cycle against a behavioural model.
module tb_rr_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       lock = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            owner;
    logic [WIDTH-1:0]      q;
    logic                  wr_valid;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit         m_busy;
    int         m_owner;
    int         m_last;
    int         m_hold;
    logic [7:0] m_q;
    bit         m_wv;

    always #5 clk = ~clk;

    rr_reg_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner    (owner),
        .q        (q),
        .wr_valid (wr_valid),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_hold  = 0;
        m_q     = 8'h00;
        m_wv    = 1'b0;
    endtask

    // One clock edge of the arbiter, stated directly from the rules.
    task automatic model_edge();
        int  winner;
        bit  owner_req;
        owner_req = m_busy && (req[m_owner] === 1'b1);
        if (owner_req) begin
            m_q  = wdata[m_owner*WIDTH +: WIDTH];
            m_wv = 1'b1;
        end else begin
            m_wv = 1'b0;
        end
        if (owner_req && lock[m_owner] === 1'b1 && m_hold < MAX_HOLD - 1) begin
            m_hold = m_hold + 1;
        end else begin
            m_hold = 0;
            winner = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (winner < 0 && req[(m_last + k) % NREQ] === 1'b1)
                    winner = (m_last + k) % NREQ;
            end
            if (winner >= 0) begin
                m_busy  = 1'b1;
                m_owner = winner;
                m_last  = winner;
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NREQ-1:0] eg;
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        check({tag, ".gnt"},      32'(gnt),      32'(eg));
        check({tag, ".owner"},    32'(owner),    32'(m_owner));
        check({tag, ".q"},        32'(q),        32'(m_q));
        check({tag, ".wr_valid"}, 32'(wr_valid), 32'(m_wv));
        check({tag, ".busy"},     32'(busy),     32'(m_busy));
    endtask

    // Advance one edge, update the model, compare on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear with no clock edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] seq_rot  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] seq_lock [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

    initial begin
        // Single requester: grant after one edge, write after two
        do_reset();
        req   = 4'b0001;
        wdata = 32'h0000_005A;
        step("single1");
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_wv0", 32'(wr_valid), 32'h0);
        step("single2");
        check("single_q", 32'(q), 32'h5A);
        check("single_wv1", 32'(wr_valid), 32'h1);

        // All requesting, no lock: strict rotation with wrap-around
        do_reset();
        req   = 4'b1111;
        wdata = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            step("rot");
            check("rot_gnt", 32'(gnt), 32'(seq_rot[k]));
            if (k >= 1) check("rot_q", 32'(q), 32'h10 + 32'(k - 1));
        end

        // Locked requester 0 capped at MAX_HOLD cycles
        do_reset();
        req   = 4'b0011;
        lock  = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step("lock");
            check("lock_gnt", 32'(gnt), 32'(seq_lock[k]));
        end

        // Owner drops its request while locked: no write, then re-arbitrate
        do_reset();
        wdata = 32'h3322_1100;
        req   = 4'b0100;
        lock  = 4'b0100;
        step("drop1");
        check("drop_gnt2", 32'(gnt), 32'h4);
        step("drop2");
        check("drop_q22", 32'(q), 32'h22);
        req = 4'b1000;
        step("drop3");
        check("drop_wv", 32'(wr_valid), 32'h0);
        check("drop_qhold", 32'(q), 32'h22);
        check("drop_gnt3", 32'(gnt), 32'h8);

        // Async reset while owner 3 is locked
        lock = 4'b1000;
        step("lk3a");
        step("lk3b");
        check("pre_rst_q", 32'(q), 32'h33);
        req  = 4'b1001;
        lock = 4'b0000;
        mid_reset("async_rst");
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_q", 32'(q), 32'h0);
        step("post_rst");
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // X on non-owner slices must not reach q
        do_reset();
        wdata = {{24{1'bx}}, 8'hC3};
        req   = 4'b0001;
        step("xsl1");
        step("xsl2");
        check("xslice_q", 32'(q), 32'hC3);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       req = 4'($urandom);
                1:       req = 4'b1111;
                2:       req = 4'b0001 << $urandom_range(0, 3);
                3:       req = 4'b0000;
                default: req = 4'($urandom) | 4'($urandom);
            endcase
            lock  = 4'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 63) == 0)
                mid_reset("rand_rst");
            else
                step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
